// File: rtl/dac_pattern_sequencer.sv
// DAC pattern sequencer: steps a resistor-DAC code through ramp-up,
// ramp-down, triangle or toggle sweeps at a programmable rate.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to begin a sequence (IDLE only)
//   mode       in   0 ramp up, 1 ramp down, 2 triangle, 3 toggle
//   div        in   hold period minus one, in clk cycles
//   loops      in   sweep count, 0 = run until abort
//   abort      in   stop a running sequence immediately
//   dac        out  registered DAC code
//   dac_strobe out  one-cycle pulse on every code load
//   busy       out  high while running
//   done       out  one-cycle pulse when a finite sequence completes
module dac_pattern_sequencer #(
    parameter int BITS  = 4,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [7:0]       loops,
    input  logic             abort,
    output logic [BITS-1:0]  dac,
    output logic             dac_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] M_UP   = 2'd0;
    localparam logic [1:0] M_DOWN = 2'd1;
    localparam logic [1:0] M_TRI  = 2'd2;

    // Position in a sweep; the triangle needs one extra bit.
    localparam logic [BITS:0] RAMP_LAST = (BITS+1)'((1 << BITS) - 1);
    localparam logic [BITS:0] TRI_LAST  = (BITS+1)'((2 << BITS) - 3);
    localparam logic [BITS:0] TOG_LAST  = (BITS+1)'(1);
    localparam logic [BITS:0] TRI_FOLD  = (BITS+1)'((2 << BITS) - 2);

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       loops_q;
    logic [DIV_W-1:0] presc_q;
    logic [BITS:0]    idx_q;
    logic [7:0]       sweep_q;
    logic [BITS-1:0]  dac_q;
    logic             strobe_q;
    logic             busy_q;
    logic             done_q;

    logic [BITS:0]    idx_d;
    logic [7:0]       sweep_d;
    logic [BITS:0]    last_idx;
    logic             tick;
    logic             wrap;
    logic             finish;

    // Code at position i of a sweep in pattern m.
    function automatic logic [BITS-1:0] code_of(
        input logic [1:0]  m,
        input logic [BITS:0] i
    );
        logic [BITS:0] fold;
        fold = TRI_FOLD - i;
        case (m)
            M_UP:    code_of = i[BITS-1:0];
            M_DOWN:  code_of = ~i[BITS-1:0];
            M_TRI:   code_of = i[BITS] ? fold[BITS-1:0] : i[BITS-1:0];
            default: code_of = i[0] ? '1 : '0;
        endcase
    endfunction

    always_comb begin
        last_idx = TOG_LAST;
        case (mode_q)
            M_UP:    last_idx = RAMP_LAST;
            M_DOWN:  last_idx = RAMP_LAST;
            M_TRI:   last_idx = TRI_LAST;
            default: last_idx = TOG_LAST;
        endcase
    end

    assign idx_d   = idx_q + 1'b1;
    assign sweep_d = sweep_q + 1'b1;
    assign tick    = (presc_q == div_q);
    assign wrap    = (idx_q == last_idx);
    // loops == 0 never matches, so the sweep counter just wraps.
    assign finish  = wrap && (loops_q != 8'd0) && (sweep_d == loops_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            div_q    <= '0;
            loops_q  <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            sweep_q  <= '0;
            dac_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        div_q    <= div;
                        loops_q  <= loops;
                        presc_q  <= '0;
                        idx_q    <= '0;
                        sweep_q  <= '0;
                        dac_q    <= code_of(mode, '0);
                        strobe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        dac_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tick) begin
                        presc_q <= '0;
                        if (finish) begin
                            dac_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (wrap) begin
                            idx_q    <= '0;
                            sweep_q  <= sweep_d;
                            dac_q    <= code_of(mode_q, '0);
                            strobe_q <= 1'b1;
                        end else begin
                            idx_q    <= idx_d;
                            dac_q    <= code_of(mode_q, idx_d);
                            strobe_q <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    dac_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dac        = dac_q;
    assign dac_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
